// File: rtl/fpu_csr_access_ctrl_if.sv
// Issue-side request and response channels of the FPU CSR access port.
// Master is the issue stage; slave is fpu_csr_access_ctrl.
interface fpu_csr_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [11:0] req_csr_addr;
  logic [31:0] req_rs1_data;
  logic [4:0]  req_rs1_idx;
  logic [4:0]  req_rd_idx;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [4:0]  rsp_rd_idx;
  logic [31:0] rsp_data;
  logic        rsp_illegal;

  modport master (
    output req_valid, req_funct3, req_csr_addr,
    output req_rs1_data, req_rs1_idx, req_rd_idx,
    output rsp_ready,
    input  req_ready, rsp_valid, rsp_rd_idx,
    input  rsp_data, rsp_illegal
  );

  modport slave (
    input  req_valid, req_funct3, req_csr_addr,
    input  req_rs1_data, req_rs1_idx, req_rd_idx,
    input  rsp_ready,
    output req_ready, rsp_valid, rsp_rd_idx,
    output rsp_data, rsp_illegal
  );
endinterface

// File: rtl/fpu_csr_access_ctrl.sv
// Zicsr read/modify/write sequencer for the FPU CSR block.
// Optional FPU_CSR_ADDR_CHECK_EN: non-FPU CSR addresses are illegal.
module fpu_csr_access_ctrl (
  input  logic        clk,
  input  logic        rst_l,
  fpu_csr_access_ctrl_if.slave bus,
  input  logic        fpu_busy,
  output logic        CSR_Read,
  output logic        CSR_Write,
  output logic [11:0] CSR_Addr,
  output logic [31:0] CSR_Write_Data,
  input  logic [31:0] CSR_Read_Data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  op_q;
  logic [11:0] addr_q;
  logic [4:0]  rd_q;
  logic [31:0] opnd_q;
  logic [31:0] old_q;
  logic        wr_q;
  logic        ill_q;

  logic        accept;
  logic        is_rw;
  logic        f3_bad;
  logic        addr_bad;
  logic        req_ill;
  logic        req_rd;
  logic        req_wr;
  logic [31:0] wdata;

  assign bus.req_ready = (state_q == IDLE) & ~fpu_busy & rst_l;
  assign accept = bus.req_valid & bus.req_ready;

  assign is_rw  = bus.req_funct3[1:0] == 2'b01;
  assign f3_bad = bus.req_funct3[1:0] == 2'b00;

`ifdef FPU_CSR_ADDR_CHECK_EN
  assign addr_bad = (bus.req_csr_addr != 12'h001) &
                    (bus.req_csr_addr != 12'h002) &
                    (bus.req_csr_addr != 12'h003);
`else
  assign addr_bad = 1'b0;
`endif

  assign req_ill = f3_bad | addr_bad;
  assign req_rd  = ~(is_rw & (bus.req_rd_idx == 5'd0));
  assign req_wr  = is_rw | (bus.req_rs1_idx != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_l) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_ill)     state_d = RESP;
          else if (req_rd) state_d = READ;
          else             state_d = WRITE;
        end
      end
      READ:    state_d = wr_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // old_q is cleared on accept so write-only and illegal report 0
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      op_q   <= 2'b00;
      addr_q <= 12'h000;
      rd_q   <= 5'd0;
      opnd_q <= 32'h0;
      old_q  <= 32'h0;
      wr_q   <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= bus.req_funct3[1:0];
        addr_q <= bus.req_csr_addr;
        rd_q   <= bus.req_rd_idx;
        opnd_q <= bus.req_funct3[2] ?
                  {27'b0, bus.req_rs1_idx} :
                  bus.req_rs1_data;
        old_q  <= 32'h0;
        wr_q   <= req_wr;
        ill_q  <= req_ill;
      end
      if (state_q == READ) old_q <= CSR_Read_Data;
    end
  end

  always_comb begin
    wdata = 32'h0;
    unique case (op_q)
      2'b01:   wdata = opnd_q;
      2'b10:   wdata = old_q | opnd_q;
      2'b11:   wdata = old_q & ~opnd_q;
      default: wdata = 32'h0;
    endcase
  end

  // strobes gated by rst_l so a reset in READ/WRITE aborts at once
  assign CSR_Read  = (state_q == READ) & rst_l;
  assign CSR_Write = (state_q == WRITE) & rst_l;
  assign CSR_Addr  = (CSR_Read | CSR_Write) ? addr_q : 12'h000;
  assign CSR_Write_Data = CSR_Write ? wdata : 32'h0;

  assign bus.rsp_valid   = state_q == RESP;
  assign bus.rsp_data    = bus.rsp_valid ? old_q : 32'h0;
  assign bus.rsp_illegal = bus.rsp_valid & ill_q;
  assign bus.rsp_rd_idx  = rd_q;

endmodule

// File: tb/tb_fpu_csr_access_ctrl.sv
// Directed bench for fpu_csr_access_ctrl with a small FPU CSR block model.
// Covers RW/RS/RCI/RWI, busy stall, illegal, back-to-back, reset abort.
module tb_fpu_csr_access_ctrl;
  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        fpu_busy = 1'b0;
  logic        CSR_Read;
  logic        CSR_Write;
  logic [11:0] CSR_Addr;
  logic [31:0] CSR_Write_Data;
  logic [31:0] CSR_Read_Data;

  fpu_csr_access_ctrl_if bus();

  fpu_csr_access_ctrl dut (
    .clk            (clk),
    .rst_l          (rst_l),
    .bus            (bus),
    .fpu_busy       (fpu_busy),
    .CSR_Read       (CSR_Read),
    .CSR_Write      (CSR_Write),
    .CSR_Addr       (CSR_Addr),
    .CSR_Write_Data (CSR_Write_Data),
    .CSR_Read_Data  (CSR_Read_Data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int acc_cnt = 0;
  int viol = 0;
  int acc_t [0:15];
  logic [11:0] last_wa = 12'h0;
  logic [31:0] last_wd = 32'h0;
  logic [4:0]  fflags = 5'h0;
  logic [2:0]  frm = 3'h0;

  always_comb begin
    CSR_Read_Data = 32'h0;
    case (CSR_Addr)
      12'h001: CSR_Read_Data = {27'b0, fflags};
      12'h002: CSR_Read_Data = {29'b0, frm};
      12'h003: CSR_Read_Data = {24'b0, frm, fflags};
      default: CSR_Read_Data = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    cyc++;
    if (bus.req_valid && bus.req_ready) begin
      acc_t[acc_cnt % 16] = cyc;
      acc_cnt++;
    end
    if (CSR_Read) rd_cnt++;
    if (CSR_Write) begin
      wr_cnt++;
      last_wa = CSR_Addr;
      last_wd = CSR_Write_Data;
      case (CSR_Addr)
        12'h001: fflags <= CSR_Write_Data[4:0];
        12'h002: frm <= CSR_Write_Data[2:0];
        12'h003: begin
          fflags <= CSR_Write_Data[4:0];
          frm <= CSR_Write_Data[7:5];
        end
        default: ;
      endcase
    end
    if (!CSR_Read && !CSR_Write && CSR_Addr != 12'h0) viol++;
    if (!CSR_Write && CSR_Write_Data != 32'h0) viol++;
  end

  task automatic do_req(
    input  logic [2:0]  f3,
    input  logic [11:0] a,
    input  logic [31:0] d,
    input  logic [4:0]  r1,
    input  logic [4:0]  rd,
    output int          lat
  );
    int g;
    @(negedge clk);
    bus.req_funct3 = f3;
    bus.req_csr_addr = a;
    bus.req_rs1_data = d;
    bus.req_rs1_idx = r1;
    bus.req_rd_idx = rd;
    bus.req_valid = 1'b1;
    g = 0;
    while (!bus.req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (g >= 20) begin
      checks++;
      errs++;
      $display("FAIL accept_timeout got=no_accept exp=accept");
    end
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat++;
    end while (!bus.rsp_valid && lat < 10);
  endtask

  task automatic finish_rsp;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin
      errs++;
      $display("FAIL rst_req_ready got=%b exp=0", bus.req_ready);
    end
    checks++;
    if ({CSR_Read, CSR_Write, CSR_Addr, CSR_Write_Data} !== 46'h0) begin
      errs++;
      $display("FAIL rst_csr got=%b%b %h %h exp=0",
               CSR_Read, CSR_Write, CSR_Addr, CSR_Write_Data);
    end
    checks++;
    if ({bus.rsp_valid, bus.rsp_data, bus.rsp_rd_idx,
         bus.rsp_illegal} !== 39'h0) begin
      errs++;
      $display("FAIL rst_rsp got=%b %h %h %b exp=0", bus.rsp_valid,
               bus.rsp_data, bus.rsp_rd_idx, bus.rsp_illegal);
    end
    rst_l = 1'b1;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL post_rst_ready got=%b exp=1", bus.req_ready);
    end
  endtask

  task automatic test_rw;
    int lat;
    int r0;
    int w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(3'b001, 12'h002, 32'h5, 5'd1, 5'd3, lat);
    checks++;
    if (lat !== 3 || bus.rsp_data !== 32'h0 ||
        bus.rsp_rd_idx !== 5'd3) begin
      errs++;
      $display("FAIL rw_rsp got=lat%0d %h rd%0d exp=lat3 0 rd3",
               lat, bus.rsp_data, bus.rsp_rd_idx);
    end
    checks++;
    if (rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1 ||
        last_wa !== 12'h002 || last_wd !== 32'h5) begin
      errs++;
      $display("FAIL rw_bus got=r%0d w%0d %h %h exp=r1 w1 002 5",
               rd_cnt - r0, wr_cnt - w0, last_wa, last_wd);
    end
    finish_rsp();
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(3'b010, 12'h002, 32'hFFFF, 5'd0, 5'd4, lat);
    checks++;
    if (lat !== 2 || bus.rsp_data !== 32'h5 ||
        rd_cnt - r0 !== 1 || wr_cnt - w0 !== 0) begin
      errs++;
      $display("FAIL rs_ro got=lat%0d %h r%0d w%0d exp=lat2 5 r1 w0",
               lat, bus.rsp_data, rd_cnt - r0, wr_cnt - w0);
    end
    finish_rsp();
  endtask

  task automatic test_rci;
    int lat;
    do_req(3'b001, 12'h003, 32'hE3, 5'd2, 5'd1, lat);
    checks++;
    if (bus.rsp_data !== 32'hA0) begin
      errs++;
      $display("FAIL fcsr_rw got=%h exp=a0", bus.rsp_data);
    end
    finish_rsp();
    do_req(3'b111, 12'h003, 32'hFFFF_FFFF, 5'd3, 5'd2, lat);
    checks++;
    if (lat !== 3 || bus.rsp_data !== 32'hE3 ||
        last_wd !== 32'hE0 || last_wa !== 12'h003) begin
      errs++;
      $display("FAIL rci got=lat%0d %h wd=%h wa=%h exp=lat3 e3 e0 003",
               lat, bus.rsp_data, last_wd, last_wa);
    end
    finish_rsp();
  endtask

  task automatic test_rwi;
    int lat;
    int r0;
    int w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(3'b101, 12'h001, 32'h0, 5'h1F, 5'd0, lat);
    checks++;
    if (lat !== 2 || bus.rsp_data !== 32'h0 || rd_cnt - r0 !== 0 ||
        wr_cnt - w0 !== 1 || last_wd !== 32'h1F ||
        last_wa !== 12'h001) begin
      errs++;
      $display("FAIL rwi got=lat%0d %h r%0d w%0d wd=%h exp=lat2 0 r0 w1 1f",
               lat, bus.rsp_data, rd_cnt - r0, wr_cnt - w0, last_wd);
    end
    finish_rsp();
  endtask

  task automatic test_busy;
    int r0;
    int w0;
    int g;
    @(negedge clk);
    fpu_busy = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_csr_addr = 12'h001;
    bus.req_rs1_data = 32'h0;
    bus.req_rs1_idx = 5'd0;
    bus.req_rd_idx = 5'd5;
    bus.req_valid = 1'b1;
    r0 = rd_cnt;
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (bus.req_ready !== 1'b0) begin
        errs++;
        $display("FAIL busy_ready cyc%0d got=%b exp=0", i, bus.req_ready);
      end
      @(negedge clk);
    end
    checks++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      errs++;
      $display("FAIL busy_strobes got=r%0d w%0d exp=r0 w0",
               rd_cnt - r0, wr_cnt - w0);
    end
    fpu_busy = 1'b0;
    #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL unbusy_ready got=%b exp=1", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (CSR_Read !== 1'b1 || CSR_Addr !== 12'h001) begin
      errs++;
      $display("FAIL unbusy_read got=%b %h exp=1 001", CSR_Read, CSR_Addr);
    end
    g = 0;
    while (!bus.rsp_valid && g < 10) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1F ||
        bus.rsp_rd_idx !== 5'd5) begin
      errs++;
      $display("FAIL unbusy_rsp got=%b %h %0d exp=1 1f 5",
               bus.rsp_valid, bus.rsp_data, bus.rsp_rd_idx);
    end
    finish_rsp();
  endtask

  task automatic test_illegal;
    int lat;
    int r0;
    int w0;
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(3'b100, 12'h001, 32'h1, 5'd3, 5'd7, lat);
    checks++;
    if (lat !== 1 || bus.rsp_illegal !== 1'b1 ||
        bus.rsp_data !== 32'h0 || bus.rsp_rd_idx !== 5'd7) begin
      errs++;
      $display("FAIL ill_rsp got=lat%0d ill%b %h rd%0d exp=lat1 ill1 0 rd7",
               lat, bus.rsp_illegal, bus.rsp_data, bus.rsp_rd_idx);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_illegal !== 1'b1 ||
          bus.rsp_data !== 32'h0 || bus.rsp_rd_idx !== 5'd7) begin
        errs++;
        $display("FAIL ill_hold cyc%0d got=%b %b %h %0d exp=1 1 0 7", i,
                 bus.rsp_valid, bus.rsp_illegal, bus.rsp_data,
                 bus.rsp_rd_idx);
      end
    end
    checks++;
    if (rd_cnt != r0 || wr_cnt != w0) begin
      errs++;
      $display("FAIL ill_strobes got=r%0d w%0d exp=r0 w0",
               rd_cnt - r0, wr_cnt - w0);
    end
    finish_rsp();
    r0 = rd_cnt;
    w0 = wr_cnt;
    do_req(3'b001, 12'h300, 32'h55, 5'd1, 5'd2, lat);
`ifdef FPU_CSR_ADDR_CHECK_EN
    checks++;
    if (lat !== 1 || bus.rsp_illegal !== 1'b1 || bus.rsp_data !== 32'h0 ||
        rd_cnt != r0 || wr_cnt != w0) begin
      errs++;
      $display("FAIL bad_addr got=lat%0d ill%b %h r%0d w%0d exp=lat1 1 0 0 0",
               lat, bus.rsp_illegal, bus.rsp_data, rd_cnt - r0, wr_cnt - w0);
    end
`else
    checks++;
    if (lat !== 3 || bus.rsp_illegal !== 1'b0 || bus.rsp_data !== 32'h0 ||
        rd_cnt - r0 !== 1 || wr_cnt - w0 !== 1) begin
      errs++;
      $display("FAIL any_addr got=lat%0d ill%b %h r%0d w%0d exp=lat3 0 0 1 1",
               lat, bus.rsp_illegal, bus.rsp_data, rd_cnt - r0, wr_cnt - w0);
    end
`endif
    finish_rsp();
  endtask

  task automatic test_back_to_back;
    int base;
    int w0;
    int g;
    int dt;
    @(negedge clk);
    base = acc_cnt;
    w0 = wr_cnt;
    bus.req_funct3 = 3'b001;
    bus.req_csr_addr = 12'h002;
    bus.req_rs1_data = 32'h1;
    bus.req_rs1_idx = 5'd1;
    bus.req_rd_idx = 5'd1;
    bus.req_valid = 1'b1;
    bus.rsp_ready = 1'b1;
    g = 0;
    while (acc_cnt < base + 2 && g < 30) begin
      @(negedge clk);
      g++;
    end
    bus.req_valid = 1'b0;
    dt = acc_t[(base + 1) % 16] - acc_t[base % 16];
    checks++;
    if (acc_cnt != base + 2 || dt != 4) begin
      errs++;
      $display("FAIL b2b_spacing got=acc%0d dt%0d exp=acc2 dt4",
               acc_cnt - base, dt);
    end
    repeat (6) @(negedge clk);
    bus.rsp_ready = 1'b0;
    checks++;
    if (wr_cnt - w0 !== 2 || bus.rsp_valid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_done got=w%0d v%b exp=w2 v0",
               wr_cnt - w0, bus.rsp_valid);
    end
  endtask

  task automatic test_reset_abort;
    int w0;
    @(negedge clk);
    bus.req_funct3 = 3'b001;
    bus.req_csr_addr = 12'h002;
    bus.req_rs1_data = 32'h7;
    bus.req_rs1_idx = 5'd1;
    bus.req_rd_idx = 5'd9;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (CSR_Read !== 1'b1) begin
      errs++;
      $display("FAIL abort_in_read got=%b exp=1", CSR_Read);
    end
    w0 = wr_cnt;
    rst_l = 1'b0;
    #1;
    checks++;
    if (CSR_Read !== 1'b0 || CSR_Write !== 1'b0 ||
        CSR_Addr !== 12'h0) begin
      errs++;
      $display("FAIL abort_drop got=%b %b %h exp=0 0 0",
               CSR_Read, CSR_Write, CSR_Addr);
    end
    @(negedge clk);
    checks++;
    if ({CSR_Read, CSR_Write, CSR_Addr, CSR_Write_Data, bus.req_ready,
         bus.rsp_valid, bus.rsp_data, bus.rsp_rd_idx,
         bus.rsp_illegal} !== 86'h0) begin
      errs++;
      $display("FAIL abort_outs got=%b%b %h %h %b %b %h %h %b exp=0",
               CSR_Read, CSR_Write, CSR_Addr, CSR_Write_Data,
               bus.req_ready, bus.rsp_valid, bus.rsp_data,
               bus.rsp_rd_idx, bus.rsp_illegal);
    end
    rst_l = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (wr_cnt != w0 || frm !== 3'h1 || bus.req_ready !== 1'b1) begin
      errs++;
      $display("FAIL abort_after got=w%0d frm%0d rdy%b exp=w0 frm1 rdy1",
               wr_cnt - w0, frm, bus.req_ready);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_csr_addr = 12'h0;
    bus.req_rs1_data = 32'h0;
    bus.req_rs1_idx = 5'd0;
    bus.req_rd_idx = 5'd0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_rw();
    test_rci();
    test_rwi();
    test_busy();
    test_illegal();
    test_back_to_back();
    test_reset_abort();
    checks++;
    if (viol !== 0) begin
      errs++;
      $display("FAIL idle_bus_zero got=%0d exp=0", viol);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=timeout exp=finish");
    $fatal(1);
  end
endmodule
